// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: multi-beat opcode numbers and sequencer states.
package cpu_pkg;

  localparam logic [3:0] OP_LDW = 4'd8;
  localparam logic [3:0] OP_SDW = 4'd9;
  localparam logic [3:0] OP_LDQ = 4'd10;
  localparam logic [3:0] OP_SDQ = 4'd11;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

endpackage

// File: rtl/beat_decode.sv
// Combinational opcode/rd decode: sequence length (as n-1), multi-beat flag and rd alignment.
module beat_decode
  import cpu_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int RD_W      = 4,
  parameter int MAX_BEATS = 4,
  localparam int CNT_W    = $clog2(MAX_BEATS)
) (
  input  logic              valid,
  input  logic [OP_W-1:0]   op_code,
  input  logic [RD_W-1:0]   rd,
  output logic [CNT_W-1:0]  nlen,
  output logic              multi,
  output logic              aligned
);

  // Upper opcode bits and high rd bits play no part in the beat decode.
  logic unused_bits;
  assign unused_bits = ^{op_code[OP_W-1:4], rd[RD_W-1:2]};

  // Map the low opcode nibble to a beat count; quad ops collapse to one beat on a 2-beat build.
  always_comb begin
    nlen    = '0;
    aligned = 1'b1;
    case (op_code[3:0])
      OP_LDW, OP_SDW: begin
        nlen    = CNT_W'(1);
        aligned = ~rd[0];
      end
      OP_LDQ, OP_SDQ: begin
        if (MAX_BEATS >= 4) begin
          nlen    = CNT_W'(3);
          aligned = (rd[1:0] == 2'b00);
        end
      end
      default: ;
    endcase
    multi = valid & (nlen != '0);
  end

endmodule

// File: rtl/multi_beat_cu.sv
// Decode-stage multi-beat sequencer: splits double/quad load/store into consecutive beats,
// holds the PC until the final beat and flags misaligned register bases.
module multi_beat_cu
  import cpu_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int RD_W      = 4,
  parameter int MAX_BEATS = 4,
  parameter int IMM_SH    = 0,
  parameter int IMM_W     = 8,
  localparam int CNT_W    = $clog2(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid,
  input  logic [OP_W-1:0]   op_code,
  input  logic [RD_W-1:0]   rd,
  output logic              adv_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  beat,
  output logic [CNT_W-1:0]  rd_offset,
  output logic [IMM_W-1:0]  imm_offset,
  output logic              last_beat,
  output logic              misalign
);

  localparam int FULL_W = CNT_W + IMM_SH + IMM_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nlen_q, nlen_d;
  logic [CNT_W-1:0]   dec_nlen;
  logic               dec_multi;
  logic               dec_aligned;

  // Beat index scaled into the immediate offset, zero-extended or truncated to IMM_W.
  function automatic logic [IMM_W-1:0] imm_of(input logic [CNT_W-1:0] b);
    logic [FULL_W-1:0] wide;
    wide = FULL_W'(b) << IMM_SH;
    return wide[IMM_W-1:0];
  endfunction

  beat_decode #(
    .OP_W      (OP_W),
    .RD_W      (RD_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_beat_decode (
    .valid   (valid),
    .op_code (op_code),
    .rd      (rd),
    .nlen    (dec_nlen),
    .multi   (dec_multi),
    .aligned (dec_aligned)
  );

  // Sequencer state, beat counter and latched sequence length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nlen_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nlen_q  <= nlen_d;
    end
  end

  // Next-state and beat outputs; flush overrides stall, stall freezes the current beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nlen_d    = nlen_q;
    beat      = '0;
    busy      = 1'b0;
    misalign  = 1'b0;
    last_beat = 1'b1;
    case (state_q)
      ST_IDLE: begin
        misalign  = dec_multi & ~dec_aligned;
        last_beat = ~(dec_multi & dec_aligned);
        cnt_d     = '0;
        if (dec_multi && dec_aligned && !stall && !flush) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(1);
          nlen_d  = dec_nlen;
        end
      end
      ST_RUN: begin
        beat      = cnt_q;
        busy      = 1'b1;
        last_beat = (cnt_q == nlen_q);
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!stall) begin
          if (cnt_q == nlen_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign adv_pc     = last_beat;
  assign rd_offset  = beat;
  assign imm_offset = imm_of(beat);

endmodule

// File: doc/multi_beat_cu.md
# multi_beat_cu

Parametrised multi-beat sequencer in the decode stage. It splits double- and quad-word load/store instructions into N consecutive register/immediate beats. It holds the PC until the last beat issues and flags misaligned destination registers. It runs on the pipeline clock and takes the hazard unit's stall and the branch unit's flush. It feeds the PC-select logic, the register-file address adder and the immediate adder.

## Interface
Parameters:
- OP_W, 6, opcode width
- RD_W, 4, destination register field width
- MAX_BEATS, 4, largest sequence length; power of two, 2 or 4
- CNT_W, $clog2(MAX_BEATS), beat counter width (localparam, derived)
- IMM_SH, 0, left shift applied to beat index to form immediate offset
- IMM_W, 8, immediate offset width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode stage stalled; freeze sequencer
- flush  in  1  squash decode; abort any sequence
- valid  in  1  decode holds a real instruction
- op_code  in  OP_W  opcode of decode instruction
- rd  in  RD_W  destination/source register base
- adv_pc  out  1  1 = PC may advance this cycle
- busy  out  1  sequence in progress (state RUN)
- beat  out  CNT_W  current beat index
- rd_offset  out  CNT_W  added to rd by register-address adder (= beat)
- imm_offset  out  IMM_W  beat << IMM_SH, zero-extended
- last_beat  out  1  current beat is final beat of the instruction
- misalign  out  1  multi-beat op with rd not a multiple of its beat count

## Operation
- Decode (op_code[3:0]): 8, 9 → n=2; 10, 11 → n=4 if MAX_BEATS≥4, otherwise n=1. Any other value → n=1. Upper opcode bits are ignored.
- multi = valid & (n>1). aligned = (rd mod n)==0.
- FSM states: IDLE, RUN. Registers: state, cnt[CNT_W], nlen (latched n−1).
- IDLE, combinational outputs:
  - beat=0, busy=0.
  - misalign = multi & ~aligned.
  - last_beat = ~(multi & aligned).
  - adv_pc = last_beat.
- IDLE → RUN when multi & aligned & ~stall & ~flush. On that transition, cnt←1 and nlen←n−1.
- A misaligned op does not start a sequence. It issues as a single beat with adv_pc=1 and is trapped downstream.
- RUN outputs:
  - beat=cnt, busy=1, misalign=0.
  - last_beat = (cnt==nlen), adv_pc = last_beat.
  - op_code and rd are ignored; the pipeline holds the instruction while the PC is held.
- RUN advance with ~stall: if cnt==nlen → IDLE, cnt←0; else cnt←cnt+1.
- stall in either state: state and cnt hold, and outputs stay those of the current beat.
- flush: next state IDLE, cnt←0, regardless of stall (flush wins).
- rd_offset = beat. imm_offset = {beat, IMM_SH zeros}, truncated or zero-extended to IMM_W.

## Timing
- Reset (async assert, sync-safe deassert by the top level): state IDLE, cnt 0, nlen 0.
- Output values during reset:
  - With valid=0: adv_pc=1, busy=0, beat=0, rd_offset=0, imm_offset=0, last_beat=1, misalign=0.
  - With valid=1: only adv_pc, last_beat and misalign follow the combinational decode rules.
- An n-beat aligned op with no stalls occupies decode for exactly n cycles. adv_pc is 0 for the first n−1 cycles and 1 in cycle n.
- Each stalled cycle adds exactly one cycle and does not repeat or skip any beat index.
- Flush in a RUN cycle: that cycle's beat is squashed downstream, and the next cycle is IDLE with fresh decode.
- Back-to-back multi-beat ops: in the cycle after the last beat, IDLE decodes the next op and may start immediately, with no bubble.
- Reset mid-sequence: the FSM returns to IDLE immediately, and the partial sequence is discarded.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_LDW=8, OP_SDW=9, OP_LDQ=10, OP_SDQ=11.
  - state enum {ST_IDLE, ST_RUN}.
- Sub-module `beat_decode`: combinational op_code/rd → n, multi, aligned.
- Counter, FSM and output muxing are in the top module.
- Target size ~150–250 lines.

## Test plan
- Reset with valid=0: adv_pc=1, busy=0, beat=0, misalign=0. op=1 is a single-beat op: adv_pc=1 and state stays IDLE.
- op=8, rd=2, no stall: cycle 1 beat=0, adv_pc=0; cycle 2 beat=1, adv_pc=1, last_beat=1; cycle 3 busy=0.
- op=10, rd=4, MAX_BEATS=4, IMM_SH=2: beats 0,1,2,3 give imm_offset 0,4,8,12, and adv_pc=1 only on beat 3. The same op with MAX_BEATS=2 completes in 1 cycle.
- op=9, rd=3: misalign=1, adv_pc=1, busy stays 0. op=10, rd=6: misalign=1.
- op=10, rd=0, with stall high for 2 cycles at beat 1: beat sequence 0,1,1,1,2,3, and adv_pc=1 only on the final beat-3 cycle.
- op=10 with flush at beat 2: the next cycle is IDLE. Flush and stall together in RUN also yield IDLE. Asserting rst_n low mid-sequence clears busy asynchronously.
